// File: rtl/core_seq_if.sv
// Host- and core-facing signal bundle of the tile instruction sequencer.
// The host (master) supplies operands and ofifo_valid; the sequencer (slave) returns inst/busy/done.
interface core_seq_if #(
  parameter int addr_w = 11,
  parameter int cnt_w  = 7
);
  logic              start;
  logic [addr_w-1:0] w_base;
  logic [addr_w-1:0] a_base;
  logic [addr_w-1:0] p_base;
  logic [cnt_w-1:0]  num_act;
  logic              acc_en;
  logic              relu_en;
  logic              ofifo_valid;
  logic [34:0]       inst;
  logic              busy;
  logic              done;

  modport master (
    output start, w_base, a_base, p_base, num_act, acc_en, relu_en, ofifo_valid,
    input  inst, busy, done
  );

  modport slave (
    input  start, w_base, a_base, p_base, num_act, acc_en, relu_en, ofifo_valid,
    output inst, busy, done
  );
endinterface

// File: rtl/core_seq.sv
// Tile instruction sequencer: weight fetch/kernel load, activation fetch/execute, OFIFO drain to pmem.
// Every output is a register computed from the current state, so inst trails the state by one cycle.
module core_seq #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int addr_w = 11,
  parameter int cnt_w  = 7
) (
  input logic       clk,
  input logic       reset,
  core_seq_if.slave bus
);

  localparam int CNT_W = cnt_w + 1;

  localparam int KLOAD_B = 0;
  localparam int EXEC_B  = 1;
  localparam int L0WR_B  = 2;
  localparam int L0RD_B  = 3;
  localparam int ORD_B   = 6;
  localparam int XWEN_B  = 18;
  localparam int XCEN_B  = 19;
  localparam int PWEN_B  = 31;
  localparam int PCEN_B  = 32;

  // Both memories disabled (CEN=WEN=1), everything else clear.
  localparam logic [34:0] IDLE_WORD = 35'h1_800C_0000;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] COL_C    = CNT_W'(col);
  localparam logic [CNT_W-1:0] ROW_C    = CNT_W'(row);
  localparam logic [cnt_w-1:0] N_ZERO   = {cnt_w{1'b0}};
  localparam logic [cnt_w-1:0] N_ONE    = {{(cnt_w-1){1'b0}}, 1'b1};
  localparam logic [addr_w-1:0] A_ZERO  = {addr_w{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_W_L0  = 3'd1,
    S_KLOAD = 3'd2,
    S_KWAIT = 3'd3,
    S_A_L0  = 3'd4,
    S_EXEC  = 3'd5,
    S_DRAIN = 3'd6,
    S_DONE  = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [cnt_w-1:0]  rd_cnt_q, rd_cnt_d;
  logic [cnt_w-1:0]  wr_cnt_q, wr_cnt_d;
  logic [addr_w-1:0] w_base_q, w_base_d;
  logic [addr_w-1:0] a_base_q, a_base_d;
  logic [addr_w-1:0] p_base_q, p_base_d;
  logic [cnt_w-1:0]  n_q, n_d;
  logic              acc_q, acc_d;
  logic              relu_q, relu_d;
  logic [34:0]       inst_q, inst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [addr_w-1:0] fetch_base_s;
  logic [CNT_W-1:0]  fetch_len_s;
  logic [1:0]        flags_s;
  logic              rd_s;
  logic              wr_s;

  // Fetch cycle k of len+1: read xmem for k<len, write L0 with the word read one cycle earlier.
  function automatic logic [34:0] fetch_word(input logic [addr_w-1:0] base,
                                             input logic [CNT_W-1:0]  k,
                                             input logic [CNT_W-1:0]  len,
                                             input logic [1:0]        flags);
    logic [34:0] w;
    w            = {flags, IDLE_WORD[32:0]};
    w[XCEN_B]    = (k >= len);
    w[XWEN_B]    = 1'b1;
    w[17:7]      = (k < len) ? (base + addr_w'(k)) : A_ZERO;
    w[L0WR_B]    = (k != CNT_ZERO);
    return w;
  endfunction

  // Drain cycle: optional OFIFO pop plus optional pmem write of the previous pop.
  function automatic logic [34:0] drain_word(input logic              rd,
                                             input logic              wr,
                                             input logic [addr_w-1:0] waddr,
                                             input logic [1:0]        flags);
    logic [34:0] w;
    w         = {flags, IDLE_WORD[32:0]};
    w[ORD_B]  = rd;
    w[PCEN_B] = ~wr;
    w[PWEN_B] = ~wr;
    w[30:20]  = wr ? waddr : A_ZERO;
    return w;
  endfunction

  // Next-state, counter, operand-latch and output-word logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    w_base_d = w_base_q;
    a_base_d = a_base_q;
    p_base_d = p_base_q;
    n_d      = n_q;
    acc_d    = acc_q;
    relu_d   = relu_q;
    flags_s  = {relu_q, acc_q};
    inst_d   = {flags_s, IDLE_WORD[32:0]};
    busy_d   = 1'b1;
    done_d   = 1'b0;
    rd_s     = 1'b0;
    wr_s     = inst_q[ORD_B];
    fetch_base_s = (state_q == S_A_L0) ? a_base_q : w_base_q;
    fetch_len_s  = (state_q == S_A_L0) ? {1'b0, n_q} : COL_C;

    case (state_q)
      S_IDLE: begin
        inst_d = IDLE_WORD;
        busy_d = 1'b0;
        if (bus.start) begin
          w_base_d = bus.w_base;
          a_base_d = bus.a_base;
          p_base_d = bus.p_base;
          n_d      = bus.num_act;
          acc_d    = bus.acc_en;
          relu_d   = bus.relu_en;
          cnt_d    = CNT_ZERO;
          state_d  = S_W_L0;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_W_L0, S_A_L0: begin
        inst_d = fetch_word(fetch_base_s, cnt_q, fetch_len_s, flags_s);
        if (cnt_q == fetch_len_s) begin
          cnt_d   = CNT_ZERO;
          state_d = (state_q == S_W_L0) ? S_KLOAD : S_EXEC;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      S_KLOAD: begin
        inst_d[KLOAD_B] = 1'b1;
        inst_d[L0RD_B]  = 1'b1;
        if (cnt_q == COL_C - CNT_ONE) begin
          cnt_d   = CNT_ZERO;
          state_d = S_KWAIT;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      S_KWAIT: begin
        if (cnt_q == ROW_C - CNT_ONE) begin
          cnt_d   = CNT_ZERO;
          state_d = (n_q == N_ZERO) ? S_DONE : S_A_L0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      S_EXEC: begin
        inst_d[EXEC_B] = 1'b1;
        inst_d[L0RD_B] = 1'b1;
        if (cnt_q == {1'b0, n_q} - CNT_ONE) begin
          cnt_d    = CNT_ZERO;
          rd_cnt_d = N_ZERO;
          wr_cnt_d = N_ZERO;
          state_d  = S_DRAIN;
        end else begin
          cnt_d    = cnt_q + CNT_ONE;
        end
      end

      // Pops and writes overlap; leave once the write for the Nth pop goes out.
      S_DRAIN: begin
        rd_s     = bus.ofifo_valid && (rd_cnt_q < n_q);
        inst_d   = drain_word(rd_s, wr_s, p_base_q + addr_w'(wr_cnt_q), flags_s);
        rd_cnt_d = rd_cnt_q + (rd_s ? N_ONE : N_ZERO);
        if (wr_s) begin
          wr_cnt_d = wr_cnt_q + N_ONE;
          state_d  = (wr_cnt_q == n_q - N_ONE) ? S_DONE : S_DRAIN;
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        cnt_d   = CNT_ZERO;
        state_d = S_IDLE;
      end

      default: begin
        inst_d  = IDLE_WORD;
        busy_d  = 1'b0;
        cnt_d   = CNT_ZERO;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, latched operands and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      rd_cnt_q <= N_ZERO;
      wr_cnt_q <= N_ZERO;
      w_base_q <= A_ZERO;
      a_base_q <= A_ZERO;
      p_base_q <= A_ZERO;
      n_q      <= N_ZERO;
      acc_q    <= 1'b0;
      relu_q   <= 1'b0;
      inst_q   <= IDLE_WORD;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      w_base_q <= w_base_d;
      a_base_q <= a_base_d;
      p_base_q <= p_base_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      relu_q   <= relu_d;
      inst_q   <= inst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: builds the expected per-cycle inst/busy/done trace from the phase rules,
// compares it every cycle, and pins key points (addresses, done cycle, counts) with literals.
module tb_core_seq;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam int CW  = 7;
  localparam logic [34:0] IDLE_LIT = 35'h1_800C_0000;

  logic clk = 1'b0;
  logic reset;

  core_seq_if #(.addr_w(AW), .cnt_w(CW)) bus ();
  core_seq #(.row(ROW), .col(COL), .addr_w(AW), .cnt_w(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [34:0] inst; logic busy; logic done; } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;
  logic was_en = 1'b0;
  int chk_idx = 0;
  int xq[$];
  int pq[$];
  int kl_cnt, ex_cnt, done_at, flag_bad, rd_bad;

  task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  // ofifo_valid level driven during cycle c: 0 = always, 1 = 1,0,0,1,... , else never
  function automatic bit vpat(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 3) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [34:0] word_of(input bit busy, input bit acc, input bit relu);
    logic [34:0] w;
    w = IDLE_LIT;
    if (busy) begin
      w[33] = acc;
      w[34] = relu;
    end
    return w;
  endfunction

  task automatic push(input logic [34:0] w, input bit busy, input bit done);
    exp_t e;
    e.inst = w; e.busy = busy; e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic fetch_phase(input int base, input int len, input bit acc, input bit relu);
    logic [34:0] w;
    for (int k = 0; k <= len; k++) begin
      w = word_of(1'b1, acc, relu);
      if (k < len) begin
        w[19]   = 1'b0;
        w[17:7] = 11'((base + k) % 2048);
      end
      if (k > 0) w[2] = 1'b1;
      push(w, 1'b1, 1'b0);
    end
  endtask

  // Index i of exp_q is the output cycle after the i-th edge counted from the start-accepting edge.
  task automatic build(input int wb, input int ab, input int pb, input int n,
                       input bit acc, input bit relu, input int vmode);
    logic [34:0] w;
    int reads, writes;
    bit prev, rd;
    exp_q.delete();
    push(IDLE_LIT, 1'b0, 1'b0);
    fetch_phase(wb, COL, acc, relu);
    for (int k = 0; k < COL; k++) begin
      w = word_of(1'b1, acc, relu); w[0] = 1'b1; w[3] = 1'b1;
      push(w, 1'b1, 1'b0);
    end
    for (int k = 0; k < ROW; k++) push(word_of(1'b1, acc, relu), 1'b1, 1'b0);
    if (n > 0) begin
      fetch_phase(ab, n, acc, relu);
      for (int k = 0; k < n; k++) begin
        w = word_of(1'b1, acc, relu); w[1] = 1'b1; w[3] = 1'b1;
        push(w, 1'b1, 1'b0);
      end
      reads = 0; writes = 0; prev = 1'b0;
      while (writes < n && exp_q.size() < 600) begin
        w  = word_of(1'b1, acc, relu);
        rd = vpat(vmode, exp_q.size() - 1) && (reads < n);
        if (rd) begin w[6] = 1'b1; reads++; end
        if (prev) begin
          w[32] = 1'b0; w[31] = 1'b0;
          w[30:20] = 11'((pb + writes) % 2048);
          writes++;
        end
        prev = rd;
        push(w, 1'b1, 1'b0);
      end
    end
    push(word_of(1'b1, acc, relu), 1'b1, 1'b1);
    push(IDLE_LIT, 1'b0, 1'b0);
    push(IDLE_LIT, 1'b0, 1'b0);
  endtask

  // Per-cycle compare against the model, sampled 2 time units after the rising edge.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      if (!was_en) begin
        chk_idx = 0;
        xq.delete(); pq.delete();
        kl_cnt = 0; ex_cnt = 0; done_at = -1; flag_bad = 0; rd_bad = 0;
      end
      if (chk_idx < exp_q.size()) begin
        chk("inst", chk_idx, 64'(bus.inst), 64'(exp_q[chk_idx].inst));
        chk("busy", chk_idx, 64'(bus.busy), 64'(exp_q[chk_idx].busy));
        chk("done", chk_idx, 64'(bus.done), 64'(exp_q[chk_idx].done));
        if (!bus.inst[19]) xq.push_back(int'(bus.inst[17:7]));
        if (!bus.inst[32]) pq.push_back(int'(bus.inst[30:20]));
        if (bus.inst[0]) kl_cnt++;
        if (bus.inst[1]) ex_cnt++;
        if (bus.done) done_at = chk_idx;
        if (bus.busy && bus.inst[34:33] != 2'b11) flag_bad++;
        if (!bus.busy && bus.inst[34:33] != 2'b00) flag_bad++;
        if (bus.inst[6] && !bus.ofifo_valid) rd_bad++;
        chk_idx++;
      end
    end
    was_en = chk_en;
  end

  task automatic run_seq(input int wb, input int ab, input int pb, input int n,
                         input bit acc, input bit relu, input int vmode,
                         input int start_at, input int reset_at);
    build(wb, ab, pb, n, acc, relu, vmode);
    @(negedge clk);
    bus.start = 1'b1;
    bus.w_base = AW'(wb); bus.a_base = AW'(ab); bus.p_base = AW'(pb);
    bus.num_act = CW'(n); bus.acc_en = acc; bus.relu_en = relu;
    chk_en = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.w_base = AW'($urandom); bus.a_base = AW'($urandom); bus.p_base = AW'($urandom);
        bus.num_act = CW'($urandom); bus.acc_en = ~acc; bus.relu_en = ~relu;
      end
      bus.start = (i == start_at);
      bus.ofifo_valid = vpat(vmode, i);
      if (i == reset_at) begin
        reset = 1'b1;
        break;
      end
    end
    chk_en = 1'b0;
    bus.start = 1'b0;
    if (reset_at >= 0) begin
      @(negedge clk);
      reset = 1'b0;
      chk("rst_inst", reset_at + 1, 64'(bus.inst), 64'(IDLE_LIT));
      chk("rst_busy", reset_at + 1, 64'(bus.busy), 64'd0);
      chk("rst_done", reset_at + 1, 64'(bus.done), 64'd0);
    end
  endtask

  int wrap_exp[8] = '{2044, 2045, 2046, 2047, 0, 1, 2, 3};

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.w_base = '0; bus.a_base = '0; bus.p_base = '0;
    bus.num_act = '0; bus.acc_en = 1'b0; bus.relu_en = 1'b0; bus.ofifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_inst", 0, 64'(bus.inst), 64'(IDLE_LIT));
    chk("reset_busy", 0, 64'(bus.busy), 64'd0);
    chk("reset_done", 0, 64'(bus.done), 64'd0);

    // Default tile, ofifo_valid always high.
    run_seq(0, 100, 500, 16, 1'b0, 1'b0, 0, -1, -1);
    chk("A_done_cycle", 0, 64'(done_at), 64'd76);
    chk("A_kload", 0, 64'(kl_cnt), 64'd8);
    chk("A_exec", 0, 64'(ex_cnt), 64'd16);
    chk("A_xreads", 0, 64'(xq.size()), 64'd24);
    for (int i = 0; i < xq.size() && i < 24; i++)
      chk("A_xaddr", i, 64'(xq[i]), (i < 8) ? 64'(i) : 64'(100 + i - 8));
    chk("A_pwrites", 0, 64'(pq.size()), 64'd16);
    for (int j = 0; j < pq.size() && j < 16; j++) chk("A_paddr", j, 64'(pq[j]), 64'(500 + j));

    // Toggling ofifo_valid, with a start pulse during EXEC that must be ignored.
    run_seq(0, 100, 500, 16, 1'b0, 1'b0, 1, 47, -1);
    chk("B_rd_valid", 0, 64'(rd_bad), 64'd0);
    chk("B_pwrites", 0, 64'(pq.size()), 64'd16);
    for (int j = 0; j < pq.size() && j < 16; j++) chk("B_paddr", j, 64'(pq[j]), 64'(500 + j));

    // N=0: straight from KWAIT to DONE.
    run_seq(0, 100, 500, 0, 1'b0, 1'b0, 0, -1, -1);
    chk("C_done_cycle", 0, 64'(done_at), 64'd26);
    chk("C_pwrites", 0, 64'(pq.size()), 64'd0);
    chk("C_exec", 0, 64'(ex_cnt), 64'd0);

    // Address wrap at the top of xmem and pmem.
    run_seq(2044, 7, 2046, 3, 1'b0, 1'b0, 0, -1, -1);
    for (int i = 0; i < xq.size() && i < 8; i++) chk("D_wrap", i, 64'(xq[i]), 64'(wrap_exp[i]));
    chk("D_pwrap", 0, 64'(pq.size() == 3 ? pq[2] : -1), 64'd0);

    // acc/relu flags follow busy.
    run_seq(20, 40, 60, 3, 1'b1, 1'b1, 0, -1, -1);
    chk("E_flags", 0, 64'(flag_bad), 64'd0);

    // DRAIN stalls with no valid; start in EXEC ignored; reset mid-DRAIN, then rerun.
    run_seq(0, 100, 500, 16, 1'b0, 1'b0, 2, 47, 70);
    repeat (2) @(negedge clk);
    chk("F_idle_busy", 0, 64'(bus.busy), 64'd0);
    run_seq(5, 200, 1000, 4, 1'b0, 1'b0, 0, -1, -1);
    chk("G_first_xaddr", 0, 64'(xq.size() > 0 ? xq[0] : -1), 64'd5);
    chk("G_done_cycle", 0, 64'(done_at), 64'd40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
